// File: rtl/ctr_seq_ctrl.sv
// Sequencer driving an external up/down counter: one-shot down, periodic down, triangle.
// Optional 16-bit wrap counter output `cycles` when CTR_SEQ_CYCCNT_EN is defined.
module ctr_seq_ctrl #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] ctr_count,
  input  logic             ctr_tercnt,
  output logic [WIDTH-1:0] ctr_data,
  output logic             ctr_load_n,
  output logic             ctr_up_dn,
  output logic             ctr_cen,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             err
`ifdef CTR_SEQ_CYCCNT_EN
  ,
  output logic [15:0]      cycles
`endif
);

  localparam logic [1:0] M_ONE = 2'b00;
  localparam logic [1:0] M_PER = 2'b01;
  localparam logic [1:0] M_TRI = 2'b10;

  typedef enum logic [1:0] {IDLE, LOAD, RUN_DN, RUN_UP} state_t;

  state_t           state;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] per_q;
  logic             reject, accept, wrap_set;

  assign reject   = (mode == 2'b11) || (mode == M_TRI && period == '0);
  assign accept   = (state == IDLE) && start && !stop && !reject;
  assign wrap_set = !stop && (state == RUN_DN) && ctr_tercnt &&
                    (mode_q == M_PER || mode_q == M_TRI);
  assign busy     = (state != IDLE);

  // Counter controls are decoded in the same cycle so turnarounds cost no extra count.
  always_comb begin
    ctr_data   = '0;
    ctr_load_n = 1'b1;
    ctr_up_dn  = 1'b0;
    ctr_cen    = 1'b0;
    case (state)
      LOAD: begin
        ctr_load_n = 1'b0;
        ctr_data   = (mode_q == M_TRI) ? '0 : per_q;
        ctr_up_dn  = (mode_q == M_TRI);
      end
      RUN_DN: begin
        ctr_cen = 1'b1;
        if (ctr_tercnt) begin
          case (mode_q)
            M_PER: begin
              ctr_load_n = 1'b0;
              ctr_data   = per_q;
            end
            M_TRI:   ctr_up_dn = 1'b1;
            default: ctr_cen   = 1'b0;
          endcase
        end
      end
      RUN_UP: begin
        ctr_cen   = 1'b1;
        ctr_up_dn = (ctr_count != per_q);
      end
      default: ;
    endcase
    if (stop) begin
      ctr_cen    = 1'b0;
      ctr_load_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      mode_q <= 2'b00;
      per_q  <= '0;
      done   <= 1'b0;
      wrap   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= wrap_set;
      err  <= 1'b0;
      if (stop) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start && reject) err <= 1'b1;
            if (accept) begin
              mode_q <= mode;
              per_q  <= period;
              state  <= LOAD;
            end
          end
          LOAD: state <= (mode_q == M_TRI) ? RUN_UP : RUN_DN;
          RUN_DN: begin
            if (ctr_tercnt) begin
              case (mode_q)
                M_PER: state <= RUN_DN;
                M_TRI: state <= RUN_UP;
                default: begin
                  state <= IDLE;
                  done  <= 1'b1;
                end
              endcase
            end
          end
          RUN_UP: if (ctr_count == per_q) state <= RUN_DN;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef CTR_SEQ_CYCCNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  cycles <= '0;
    else if (accept)                            cycles <= '0;
    else if (wrap_set && cycles != 16'hFFFF)    cycles <= cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ctr_seq_ctrl.sv
// Bench for ctr_seq_ctrl driving a 4-bit up/down counter; expected traces come from
// closed-form arithmetic per mode and period.
module tb_ctr_seq_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, start, stop;
  logic [1:0]   mode;
  logic [W-1:0] period, ctr_count, ctr_data;
  logic         ctr_tercnt, ctr_load_n, ctr_up_dn, ctr_cen, busy, done, wrap, err;
  logic         cnt_rst_n;
`ifdef CTR_SEQ_CYCCNT_EN
  logic [15:0]  cycles;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ctr_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode), .period(period),
    .ctr_count(ctr_count), .ctr_tercnt(ctr_tercnt), .ctr_data(ctr_data),
    .ctr_load_n(ctr_load_n), .ctr_up_dn(ctr_up_dn), .ctr_cen(ctr_cen), .busy(busy),
    .done(done), .wrap(wrap), .err(err)
`ifdef CTR_SEQ_CYCCNT_EN
    , .cycles(cycles)
`endif
  );

  // Controlled counter: load beats count enable; terminal count flags zero.
  assign cnt_rst_n  = ~reset;
  assign ctr_tercnt = (ctr_count == '0);
  always_ff @(posedge clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n)       ctr_count <= '0;
    else if (!ctr_load_n) ctr_count <= ctr_data;
    else if (ctr_cen)     ctr_count <= ctr_up_dn ? ctr_count + 1'b1 : ctr_count - 1'b1;
  end

  // n = cycles since the counter was loaded (0 = first run cycle).
  function automatic void model(input int m, input int p, input int n,
                                output int cnt, output bit bsy, output bit dn, output bit wr);
    int r;
    bsy = 1'b1; dn = 1'b0; wr = 1'b0;
    if (m == 0) begin
      cnt = (n <= p) ? p - n : 0;
      bsy = (n <= p);
      dn  = (n == p + 1);
    end else if (m == 1) begin
      cnt = p - (n % (p + 1));
      wr  = (n >= 1) && (n % (p + 1) == 0);
    end else begin
      r   = n % (2 * p);
      cnt = (r <= p) ? r : 2 * p - r;
      wr  = (n > 2 * p) && (r == 1);
    end
  endfunction

  task automatic test_reset();
    #2;
    n_chk++;
    if (ctr_load_n !== 1'b1 || ctr_cen !== 1'b0 || ctr_up_dn !== 1'b0 || ctr_data !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_outputs: load_n=%b cen=%b up_dn=%b data=%0d busy=%b done=%b wrap=%b err=%b, required 1 0 0 0 0 0 0 0",
               ctr_load_n, ctr_cen, ctr_up_dn, ctr_data, busy, done, wrap, err);
    else n_pass++;
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_modes();
    int ms[$], ps[$];
    int m, p, nc, cnt;
    bit bsy, dn, wr;
    logic [W-1:0] exp_c;
    ms = '{0, 1, 2, 0, 1, 2};
    ps = '{3, 2, 3, 0, 0, 1};
    for (int i = 0; i < 10; i++) begin
      m = $urandom_range(0, 2);
      ms.push_back(m);
      ps.push_back((m == 2) ? $urandom_range(1, 15) : $urandom_range(0, 15));
    end
    foreach (ms[c]) begin
      m = ms[c]; p = ps[c];
      start = 1'b1; mode = m[1:0]; period = p[W-1:0];
      @(posedge clk); #1;
      start = 1'b0;
      nc = (m == 0) ? p + 4 : (m == 1) ? 3 * (p + 1) + 2 : 4 * p + 3;
      for (int k = 1; k <= nc; k++) begin
        @(negedge clk);
        if (k == 1) begin
          exp_c = (m == 2) ? '0 : p[W-1:0];
          n_chk++;
          if (busy !== 1'b1 || ctr_load_n !== 1'b0 || ctr_data !== exp_c)
            $display("FAIL load_cycle m%0d p%0d: busy=%b load_n=%b data=%0d, required 1 0 %0d",
                     m, p, busy, ctr_load_n, ctr_data, exp_c);
          else n_pass++;
        end else begin
          model(m, p, k - 2, cnt, bsy, dn, wr);
          exp_c = cnt[W-1:0];
          n_chk++;
          if (ctr_count !== exp_c || busy !== bsy || done !== dn || wrap !== wr)
            $display("FAIL seq m%0d p%0d n%0d: count=%0d busy=%b done=%b wrap=%b, required %0d %b %b %b",
                     m, p, k - 2, ctr_count, busy, done, wrap, exp_c, bsy, dn, wr);
          else n_pass++;
        end
        mode   = 2'($urandom);
        period = W'($urandom);
        start  = (m != 0 && k < nc) ? 1'($urandom) : 1'b0;
      end
      start = 1'b0; stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int a, b, k;
    a = $urandom_range(1, 6);
    b = $urandom_range(7, 12);
    start = 1'b1; mode = 2'b00; period = a[W-1:0];
    @(posedge clk); #1;
    period = b[W-1:0];  // start stays high: ignored while busy, taken once idle
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 2) begin
        n_chk++;
        if (ctr_count !== a[W-1:0]) $display("FAIL b2b_first_count: count=%0d required %0d", ctr_count, a);
        else n_pass++;
      end
      if (done === 1'b1) begin k = i; break; end
    end
    n_chk++;
    if (k != a + 3) $display("FAIL b2b_done_cycle: done at %0d required %0d", k, a + 3);
    else n_pass++;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_chk++;
    if (ctr_load_n !== 1'b0 || ctr_data !== b[W-1:0] || busy !== 1'b1)
      $display("FAIL b2b_restart: load_n=%b data=%0d busy=%b, required 0 %0d 1", ctr_load_n, ctr_data, busy, b);
    else n_pass++;
    repeat (b + 2) @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 || ctr_count !== '0)
      $display("FAIL b2b_second_done: done=%b busy=%b count=%0d, required 1 0 0", done, busy, ctr_count);
    else n_pass++;
  endtask

  task automatic test_stop();
    bit found = 1'b0;
    start = 1'b1; mode = 2'b01; period = 4'd9;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy === 1'b1 && ctr_load_n === 1'b1 && ctr_count === 4'd5) begin found = 1'b1; break; end
    end
    n_chk++;
    if (!found) $display("FAIL stop_reach5: count=%0d never reached 5", ctr_count);
    else n_pass++;
    stop = 1'b1; #1;
    n_chk++;
    if (ctr_cen !== 1'b0 || ctr_load_n !== 1'b1)
      $display("FAIL stop_comb: cen=%b load_n=%b, required 0 1", ctr_cen, ctr_load_n);
    else n_pass++;
    @(posedge clk); #1;
    stop = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || ctr_count !== 4'd5 || wrap !== 1'b0)
      $display("FAIL stop_idle: busy=%b count=%0d wrap=%b, required 0 5 0", busy, ctr_count, wrap);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++;
    if (ctr_count !== 4'd5 || wrap !== 1'b0 || busy !== 1'b0)
      $display("FAIL stop_frozen: count=%0d wrap=%b busy=%b, required 5 0 0", ctr_count, wrap, busy);
    else n_pass++;
    start = 1'b1; stop = 1'b1; mode = 2'b00; period = 4'd3;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || err !== 1'b0 || ctr_load_n !== 1'b1)
        $display("FAIL start_stop_idle: busy=%b err=%b load_n=%b, required 0 0 1", busy, err, ctr_load_n);
      else n_pass++;
    end
  endtask

  task automatic test_reject();
    logic [1:0]   rm[2];
    logic [W-1:0] rp[2];
    rm[0] = 2'b11; rp[0] = W'($urandom);
    rm[1] = 2'b10; rp[1] = '0;
    for (int i = 0; i < 2; i++) begin
      start = 1'b1; mode = rm[i]; period = rp[i];
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      n_chk++;
      if (err !== 1'b1 || busy !== 1'b0)
        $display("FAIL reject_err m%0d: err=%b busy=%b, required 1 0", rm[i], err, busy);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if (err !== 1'b0 || busy !== 1'b0)
        $display("FAIL reject_after m%0d: err=%b busy=%b, required 0 0", rm[i], err, busy);
      else n_pass++;
    end
  endtask

`ifdef CTR_SEQ_CYCCNT_EN
  task automatic test_cycles();
    start = 1'b1; mode = 2'b01; period = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_chk++;
    if (cycles !== 16'd0) $display("FAIL cycles_clear: cycles=%0d required 0", cycles);
    else n_pass++;
    repeat (13) @(negedge clk);  // run cycle n=12 carries the fourth wrap
    n_chk++;
    if (cycles !== 16'd4 || wrap !== 1'b1) $display("FAIL cycles_four: cycles=%0d wrap=%b required 4 1", cycles, wrap);
    else n_pass++;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    start = 1'b1; mode = 2'b01; period = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1; #1;
    n_chk++;
    if (ctr_load_n !== 1'b1 || ctr_cen !== 1'b0 || ctr_up_dn !== 1'b0 || ctr_data !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0 || err !== 1'b0 || ctr_count !== '0)
      $display("FAIL reset_mid: load_n=%b cen=%b up_dn=%b data=%0d busy=%b done=%b wrap=%b err=%b count=%0d, required 1 0 0 0 0 0 0 0 0",
               ctr_load_n, ctr_cen, ctr_up_dn, ctr_data, busy, done, wrap, err, ctr_count);
    else n_pass++;
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || ctr_load_n !== 1'b1 || ctr_count !== '0)
      $display("FAIL reset_no_resume: busy=%b load_n=%b count=%0d, required 0 1 0", busy, ctr_load_n, ctr_count);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; period = '0;
    test_reset();
    test_modes();
    test_back_to_back();
    test_stop();
    test_reject();
`ifdef CTR_SEQ_CYCCNT_EN
    test_cycles();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
